val2_gen_pipe: RTL

- Pipelined, parametrised operand-2 generator for the EXE stage of the ARM core.
- Produces the second ALU operand (val2) and the shifter carry-out.
- Supported operand forms:
  - memory offset (12-bit zero-extended);
  - rotated 8-bit immediate;
  - register shifted by a 5-bit immediate, including the LSR/ASR #32 and RRX encodings;
  - register shifted by a register value.
- Uses a valid/ready handshake and a fixed 2-cycle latency, so it can sit behind the ID/EX register with forwarded Rm/Rs values.

---
 rtl/val2_gen_pipe.sv | 100 ++++++++++
 1 files changed

// File: rtl/val2_gen_pipe.sv
// val2_gen_pipe: two-stage ARM operand-2 generator (val2 and shifter carry) with valid/ready handshake.
module val2_gen_pipe #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      shift_operand,
    input  logic             imm,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] rm_val,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val2,
    output logic             carry_out
);
    localparam int LW = $clog2(WIDTH);
    localparam int NW = AMT_W > LW + 1 ? AMT_W : LW + 1;

    logic             s1_valid, s1_imm, s1_mem, s1_c, s2_adv, sh_c, nc, unused_rs;
    logic [11:0]      s1_op;
    logic [WIDTH-1:0] s1_rm, rr, imm_v, sh_v, nv;
    logic [AMT_W-1:0] s1_rs;
    logic [NW-1:0]    n;
    logic [LW-1:0]    r;
    logic [WIDTH:0]   lx, rx, ax;
    logic [1:0]       t;
    logic [4:0]       amt;

    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] v, input logic [LW-1:0] k);
        return (v >> k) | (v << (WIDTH - int'(k)));
    endfunction

    assign unused_rs = ^rs_val[WIDTH-1:AMT_W];
    assign s2_adv    = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;

    // LSR/ASR #0 encode a full-width shift, so they reuse the register-shift path with n=WIDTH
    always_comb begin
        t     = s1_op[6:5];
        amt   = s1_op[11:7];
        n     = s1_op[4] ? NW'(s1_rs) : (amt == 5'd0 && (t == 2'b01 || t == 2'b10)) ? NW'(WIDTH) : NW'(amt);
        r     = LW'(n);
        lx    = {1'b0, s1_rm} << n;
        rx    = {s1_rm, 1'b0} >> n;
        ax    = $signed({s1_rm, 1'b0}) >>> n;
        rr    = ror(s1_rm, r);
        sh_v  = s1_rm;
        sh_c  = s1_c;
        if (!s1_op[4] && amt == 5'd0 && t == 2'b11) begin
            sh_v = {s1_c, s1_rm[WIDTH-1:1]};
            sh_c = s1_rm[0];
        end else if (n != '0) begin
            case (t)
                2'b00:   {sh_c, sh_v} = lx;
                2'b01:   {sh_v, sh_c} = rx;
                2'b10:   {sh_v, sh_c} = ax;
                default: {sh_c, sh_v} = (r == '0) ? {s1_rm[WIDTH-1], s1_rm} : {rr[WIDTH-1], rr};
            endcase
        end
        imm_v = ror({{(WIDTH-8){1'b0}}, s1_op[7:0]}, LW'({s1_op[11:8], 1'b0}));
        nv    = s1_mem ? {{(WIDTH-12){1'b0}}, s1_op} : s1_imm ? imm_v : sh_v;
        nc    = s1_mem ? s1_c : s1_imm ? ((s1_op[11:8] == 4'd0) ? s1_c : imm_v[WIDTH-1]) : sh_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_imm    <= 1'b0;
            s1_mem    <= 1'b0;
            s1_c      <= 1'b0;
            s1_op     <= '0;
            s1_rm     <= '0;
            s1_rs     <= '0;
            out_valid <= 1'b0;
            val2      <= '0;
            carry_out <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_ready && in_valid) begin
                s1_imm <= imm;
                s1_mem <= mem_read || mem_write;
                s1_c   <= c_in;
                s1_op  <= shift_operand;
                s1_rm  <= rm_val;
                s1_rs  <= rs_val[AMT_W-1:0];
            end
            if (s2_adv) out_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                val2      <= nv;
                carry_out <= nc;
            end
        end
    end
endmodule
